// File: rtl/alu_mc_unit.sv
// ============================================================================
// alu_mc_unit : multi-cycle ALU with serial arithmetic shifter and shift-add
//               multiplier behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [3:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o
);

  localparam int                CW       = SHW + 1;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_MUL  = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_ONE   = 2'd0,
    K_SHIFT = 2'd1,
    K_MUL   = 2'd2
  } kind_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic             illegal_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;

  logic [3:0]       ctrl_d;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;
  kind_t            kind_d;
  logic [SHW-1:0]   amt_d;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] mul_sum;

  always_comb begin
    ctrl_d = 4'b0000;
    res_d  = '0;
    ill_d  = 1'b0;
    kind_d = K_ONE;
    amt_d  = '0;
    case (ALUOp_i)
      3'b010: begin
        case (funct_i)
          6'h20: begin ctrl_d = 4'b0010; res_d = src1_i + src2_i; end
          6'h22: begin ctrl_d = 4'b0110; res_d = src1_i - src2_i; end
          6'h24: begin ctrl_d = 4'b0000; res_d = src1_i & src2_i; end
          6'h25: begin ctrl_d = 4'b0001; res_d = src1_i | src2_i; end
          6'h2a: begin
            ctrl_d = 4'b0111;
            res_d  = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
          end
          6'h03: begin ctrl_d = 4'b1001; kind_d = K_SHIFT; amt_d = shamt_i; end
          6'h07: begin ctrl_d = 4'b1001; kind_d = K_SHIFT; amt_d = src1_i[SHW-1:0]; end
          6'h18: begin ctrl_d = 4'b1011; kind_d = K_MUL; end
          default: ill_d = 1'b1;
        endcase
      end
      3'b001: begin ctrl_d = 4'b0110; res_d = src1_i - src2_i; end
      3'b011: begin
        ctrl_d = 4'b1000;
        res_d  = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      end
      3'b100: begin ctrl_d = 4'b0001; res_d = src1_i | src2_i; end
      3'b101: begin ctrl_d = 4'b1100; res_d = src2_i << (WIDTH/2); end
      default: ill_d = 1'b1;
    endcase
  end

  assign shift_nxt = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
  assign mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= 4'b0000;
      result_q  <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            ctrl_q <= ctrl_d;
            busy_q <= 1'b1;
            case (kind_d)
              K_SHIFT: begin
                opa_q <= src2_i;
                if (amt_d == '0) begin
                  state_q  <= S_DONE;
                  result_q <= src2_i;
                  zero_q   <= (src2_i == '0);
                  done_q   <= 1'b1;
                end else begin
                  cnt_q   <= {1'b0, amt_d};
                  state_q <= S_SHIFT;
                end
              end
              K_MUL: begin
                opa_q   <= src1_i;
                opb_q   <= src2_i;
                acc_q   <= '0;
                cnt_q   <= CNT_MUL;
                state_q <= S_MUL;
              end
              default: begin
                state_q   <= S_DONE;
                result_q  <= res_d;
                zero_q    <= (res_d == '0);
                done_q    <= 1'b1;
                illegal_q <= ill_d;
              end
            endcase
          end
        end
        S_SHIFT: begin
          opa_q <= shift_nxt;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q  <= S_DONE;
            result_q <= shift_nxt;
            zero_q   <= (shift_nxt == '0);
            done_q   <= 1'b1;
          end
        end
        S_MUL: begin
          // Multiplicand walks left while the multiplier drains right, LSB first.
          acc_q <= mul_sum;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q  <= S_DONE;
            result_q <= mul_sum;
            zero_q   <= (mul_sum == '0);
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign ALUCtrl_o = ctrl_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign illegal_o = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc_unit.sv
// ============================================================================
// tb_alu_mc_unit : scoreboard bench for alu_mc_unit (WIDTH=32).
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [3:0]  ALUCtrl_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;
  logic        illegal_o;

  alu_mc_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ALUOp_i(ALUOp_i),
    .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
    .ALUCtrl_o(ALUCtrl_o), .result_o(result_o), .zero_o(zero_o),
    .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        ill;
    int          dcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"},  result_o, e.res);
        chk({e.name, "_zero"},    {31'd0, zero_o}, {31'd0, (e.res == 32'd0)});
        chk({e.name, "_ctrl"},    {28'd0, ALUCtrl_o}, {28'd0, e.ctrl});
        chk({e.name, "_illegal"}, {31'd0, illegal_o}, {31'd0, e.ill});
        chk({e.name, "_latency"}, cyc, e.dcyc);
        chk({e.name, "_busy"},    {31'd0, busy_o}, 32'd1);
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [3:0] ectrl, input logic [31:0] eres, input logic eill,
                       input int lat, input bit push, input bit immediate);
    int g;
    g = 0;
    if (!immediate) begin
      @(negedge clk_i);
      while (busy_o && g < 200) begin
        @(negedge clk_i);
        g++;
      end
      if (g >= 200) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    end
    start_i = 1'b1; ALUOp_i = op; funct_i = fn; src1_i = a; src2_i = b; shamt_i = sh;
    @(posedge clk_i);
    #1;
    last_acc = cyc;
    if (push) q.push_back('{nm, ectrl, eres, eill, cyc + lat - 1});
    @(negedge clk_i);
    start_i = 1'b0;
    src1_i = 32'hDEAD_BEEF; src2_i = 32'h5555_AAAA; shamt_i = 5'd31;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    chk({nm, "_drain"}, q.size(), 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    rst_i = 1'b1; start_i = 1'b1; ALUOp_i = 3'b010; funct_i = 6'h20;
    src1_i = 32'd1; src2_i = 32'd2; shamt_i = 5'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctrl",    {28'd0, ALUCtrl_o}, 32'd0);
    chk("rst_result",  result_o, 32'd0);
    chk("rst_zero",    {31'd0, zero_o}, 32'd1);
    chk("rst_busy",    {31'd0, busy_o}, 32'd0);
    chk("rst_done",    {31'd0, done_o}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    start_i = 1'b0;
    rst_i = 1'b0;

    issue("add_wrap", 3'b010, 6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, 4'b0010, 32'h8000_0000, 1'b0, 1, 1, 0);
    drain("add_wrap");

    issue("sra4", 3'b010, 6'h03, 32'h0, 32'hF000_0000, 5'd4, 4'b1001, 32'hFF00_0000, 1'b0, 5, 1, 0);
    chk("sra4_busy_n1", {31'd0, busy_o}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk_i);
      chk("sra4_busy", {31'd0, busy_o}, 32'd1);
    end
    @(negedge clk_i);
    chk("sra4_busy_after", {31'd0, busy_o}, 32'd0);
    drain("sra4");

    issue("mul", 3'b010, 6'h18, 32'h0001_0000, 32'h0001_0003, 5'd0, 4'b1011, 32'h0003_0000, 1'b0, 33, 1, 0);
    repeat (9) @(negedge clk_i);
    start_i = 1'b1; ALUOp_i = 3'b010; funct_i = 6'h20; src1_i = 32'h1; src2_i = 32'h1;
    @(negedge clk_i);
    start_i = 1'b0;
    drain("mul");

    issue("beq", 3'b001, 6'h00, 32'h1234, 32'h1234, 5'd0, 4'b0110, 32'h0, 1'b0, 1, 1, 0);
    issue("sltu", 3'b011, 6'h00, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'b1000, 32'h0, 1'b0, 1, 1, 0);
    drain("sltu");
    issue("ill_funct", 3'b010, 6'h3F, 32'h5, 32'h6, 5'd0, 4'b0000, 32'h0, 1'b1, 1, 1, 0);
    issue("ill_op", 3'b000, 6'h20, 32'h5, 32'h6, 5'd0, 4'b0000, 32'h0, 1'b1, 1, 1, 0);
    drain("ill");

    issue("sub_wrap", 3'b010, 6'h22, 32'h0, 32'h1, 5'd0, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1, 1, 0);
    a0 = last_acc;
    issue("and", 3'b010, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'b0000, 32'h00F0_00F0, 1'b0, 1, 1, 0);
    chk("back_to_back_gap", last_acc - a0, 32'd2);
    issue("or_i", 3'b100, 6'h00, 32'h1234_0000, 32'h0000_5678, 5'd0, 4'b0001, 32'h1234_5678, 1'b0, 1, 1, 0);
    issue("or_r", 3'b010, 6'h25, 32'h0000_0F00, 32'h0000_00F0, 5'd0, 4'b0001, 32'h0000_0FF0, 1'b0, 1, 1, 0);
    issue("slt_neg", 3'b010, 6'h2a, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'b0111, 32'h1, 1'b0, 1, 1, 0);
    issue("lui", 3'b101, 6'h00, 32'h0, 32'h0000_ABCD, 5'd0, 4'b1100, 32'hABCD_0000, 1'b0, 1, 1, 0);
    issue("sra0", 3'b010, 6'h03, 32'h0, 32'h1234_5678, 5'd0, 4'b1001, 32'h1234_5678, 1'b0, 1, 1, 0);
    drain("singles");

    issue("srav3", 3'b010, 6'h07, 32'h3, 32'h8000_0010, 5'd17, 4'b1001, 32'hF000_0002, 1'b0, 4, 1, 0);
    drain("srav3");
    issue("srav_mask", 3'b010, 6'h07, 32'h21, 32'h4, 5'd0, 4'b1001, 32'h2, 1'b0, 2, 1, 0);
    drain("srav_mask");
    issue("mul_neg", 3'b010, 6'h18, 32'hFFFF_FFFF, 32'h3, 5'd0, 4'b1011, 32'hFFFF_FFFD, 1'b0, 33, 1, 0);
    drain("mul_neg");

    // Long srav aborted by reset; no done may follow.
    issue("srav20", 3'b010, 6'h07, 32'h14, 32'h8000_0000, 5'd0, 4'b1001, 32'h0, 1'b0, 21, 0, 0);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_ctrl",    {28'd0, ALUCtrl_o}, 32'd0);
    chk("abort_result",  result_o, 32'd0);
    chk("abort_zero",    {31'd0, zero_o}, 32'd1);
    chk("abort_busy",    {31'd0, busy_o}, 32'd0);
    chk("abort_done",    {31'd0, done_o}, 32'd0);
    chk("abort_illegal", {31'd0, illegal_o}, 32'd0);
    rst_i = 1'b0;
    issue("post_rst_add", 3'b010, 6'h20, 32'h5, 32'h6, 5'd0, 4'b0010, 32'hB, 1'b0, 1, 1, 1);
    drain("post_rst_add");
    repeat (30) @(negedge clk_i);

    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
